light_input_conditioner: RTL and testbench

- Upstream front end for the traffic-light controller FSM: takes the nine raw asynchronous sensor/request lines and delivers clean levels on x_out, which drive controller inputs x1..x9 (x_out[0] = x1 … x_out[8] = x9).
- Per bit: synchronises to clk, debounces over a qualified sample count, produces one-cycle rise/fall pulses, and flags lines held asserted too long (stuck sensor).
- All state updates on posedge clk. The controller samples on negedge, so x_out has a half-cycle of settling margin.

---
 rtl/light_input_conditioner.sv | 173 +++++++++++++++++
 tb/tb_light_input_conditioner.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/light_input_conditioner.sv
// Sensor/request front end for the traffic-light controller: per-bit synchroniser, debounce FSM,
// registered edge pulses and a sticky stuck-high detector.
module light_input_conditioner #(
    parameter int unsigned N_IN        = 9,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CYCLES  = 4,
    parameter int unsigned CW          = 3,
    parameter int unsigned STUCK_LIMIT = 1023,
    parameter int unsigned SW          = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N_IN-1:0] raw_in,
    input  logic            stuck_clr,
    output logic [N_IN-1:0] x_out,
    output logic [N_IN-1:0] rise,
    output logic [N_IN-1:0] fall,
    output logic            chg,
    output logic [N_IN-1:0] stuck
);

    // Bit 1 of the encoding is the accepted level, so x_out falls straight out of the state.
    typedef enum logic [1:0] {
        StStableLo = 2'b00,
        StPendHi   = 2'b01,
        StStableHi = 2'b10,
        StPendLo   = 2'b11
    } state_e;

    logic [N_IN-1:0] sync_q [SYNC_STAGES];
    logic [N_IN-1:0] s;

    state_e          state_q [N_IN];
    state_e          state_d [N_IN];
    logic [CW-1:0]   cnt_q   [N_IN];
    logic [CW-1:0]   cnt_d   [N_IN];
    logic [SW-1:0]   scnt_q  [N_IN];
    logic [SW-1:0]   scnt_d  [N_IN];
    logic [N_IN-1:0] x_d;
    logic [N_IN-1:0] rise_q, rise_d;
    logic [N_IN-1:0] fall_q, fall_d;
    logic [N_IN-1:0] stuck_q, stuck_d;
    logic            chg_q;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            x_out[i] = state_q[i][1];
        end
    end

    // Debounce next state; only en=1 edges are evaluated.
    always_comb begin
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < N_IN; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (en) begin
                case (state_q[i])
                    StStableLo: begin
                        if (s[i]) begin
                            if (DEB_CYCLES == 1) begin
                                state_d[i] = StStableHi;
                                rise_d[i]  = 1'b1;
                            end else begin
                                state_d[i] = StPendHi;
                                cnt_d[i]   = CW'(1);
                            end
                        end
                    end
                    StStableHi: begin
                        if (!s[i]) begin
                            if (DEB_CYCLES == 1) begin
                                state_d[i] = StStableLo;
                                fall_d[i]  = 1'b1;
                            end else begin
                                state_d[i] = StPendLo;
                                cnt_d[i]   = CW'(1);
                            end
                        end
                    end
                    StPendHi: begin
                        if (!s[i]) begin
                            state_d[i] = StStableLo;
                            cnt_d[i]   = '0;
                        end else if (cnt_q[i] == CW'(DEB_CYCLES - 1)) begin
                            state_d[i] = StStableHi;
                            cnt_d[i]   = '0;
                            rise_d[i]  = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CW'(1);
                        end
                    end
                    StPendLo: begin
                        if (s[i]) begin
                            state_d[i] = StStableHi;
                            cnt_d[i]   = '0;
                        end else if (cnt_q[i] == CW'(DEB_CYCLES - 1)) begin
                            state_d[i] = StStableLo;
                            cnt_d[i]   = '0;
                            fall_d[i]  = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CW'(1);
                        end
                    end
                    default: begin
                        state_d[i] = StStableLo;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
            x_d[i] = state_d[i][1];
        end
    end

    // Stuck counter clears on the edge x_out drops, so it never holds a stale count while low.
    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            scnt_d[i]  = scnt_q[i];
            stuck_d[i] = stuck_q[i];
            if (stuck_clr || !x_d[i]) begin
                scnt_d[i] = '0;
            end else if (en && x_out[i] && (scnt_q[i] != SW'(STUCK_LIMIT))) begin
                scnt_d[i] = scnt_q[i] + SW'(1);
            end
            if (stuck_clr) begin
                stuck_d[i] = 1'b0;
            end else if (scnt_d[i] == SW'(STUCK_LIMIT)) begin
                stuck_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            for (int i = 0; i < N_IN; i++) begin
                state_q[i] <= StStableLo;
                cnt_q[i]   <= '0;
                scnt_q[i]  <= '0;
            end
            rise_q  <= '0;
            fall_q  <= '0;
            stuck_q <= '0;
            chg_q   <= 1'b0;
        end else begin
            sync_q[0] <= raw_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            for (int i = 0; i < N_IN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                scnt_q[i]  <= scnt_d[i];
            end
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            stuck_q <= stuck_d;
            chg_q   <= |(rise_d | fall_d);
        end
    end

    assign rise  = rise_q;
    assign fall  = fall_q;
    assign chg   = chg_q;
    assign stuck = stuck_q;

endmodule

// File: tb/tb_light_input_conditioner.sv
// Directed bench: vector table for debounce/edge behaviour plus hand sequences for en stalls,
// stuck detection and mid-debounce reset.
module tb_light_input_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [8:0] raw_in;
    logic       stuck_clr;
    logic [8:0] x_out, rise, fall, stuck;
    logic       chg;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [8:0] raw;
        logic [8:0] x;
        logic [8:0] r;
        logic [8:0] f;
        logic       c;
    } vec_t;

    vec_t tbl[$];

    light_input_conditioner #(
        .N_IN       (9),
        .SYNC_STAGES(2),
        .DEB_CYCLES (4),
        .CW         (3),
        .STUCK_LIMIT(8),
        .SW         (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .raw_in   (raw_in),
        .stuck_clr(stuck_clr),
        .x_out    (x_out),
        .rise     (rise),
        .fall     (fall),
        .chg      (chg),
        .stuck    (stuck)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge: drive en, let one posedge happen, return at the following negedge.
    task automatic step(input logic e);
        en = e;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic add_row(input logic [8:0] raw, input logic [8:0] x, input logic [8:0] r,
                           input logic [8:0] f, input logic c);
        vec_t v;
        v.raw = raw;
        v.x   = x;
        v.r   = r;
        v.f   = f;
        v.c   = c;
        tbl.push_back(v);
    endtask

    // New raw level held: five quiet edges, the accepting edge, then one more quiet edge.
    task automatic seg(input logic [8:0] raw, input logic [8:0] px, input logic [8:0] nx,
                       input logic [8:0] r, input logic [8:0] f);
        repeat (5) add_row(raw, px, 9'h0, 9'h0, 1'b0);
        add_row(raw, nx, r, f, 1'b1);
        add_row(raw, nx, 9'h0, 9'h0, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b1;
        raw_in    = '0;
        stuck_clr = 1'b0;

        // Bit 8 rise, then a 3-cycle glitch on bit 1, then bit 5 up, 4/5 swap, bit 8 down.
        seg(9'h100, 9'h000, 9'h100, 9'h100, 9'h000);
        repeat (3) add_row(9'h102, 9'h100, 9'h0, 9'h0, 1'b0);
        repeat (6) add_row(9'h100, 9'h100, 9'h0, 9'h0, 1'b0);
        seg(9'h120, 9'h100, 9'h120, 9'h020, 9'h000);
        seg(9'h110, 9'h120, 9'h110, 9'h010, 9'h020);
        seg(9'h010, 9'h110, 9'h010, 9'h000, 9'h100);

        repeat (2) @(negedge clk);
        chk("reset x_out", x_out, 0);
        chk("reset rise", rise, 0);
        chk("reset fall", fall, 0);
        chk("reset chg", chg, 0);
        chk("reset stuck", stuck, 0);
        rst = 1'b0;

        foreach (tbl[j]) begin
            raw_in = tbl[j].raw;
            step(1'b1);
            chk($sformatf("tbl[%0d] x_out", j), x_out, tbl[j].x);
            chk($sformatf("tbl[%0d] rise", j), rise, tbl[j].r);
            chk($sformatf("tbl[%0d] fall", j), fall, tbl[j].f);
            chk($sformatf("tbl[%0d] chg", j), chg, tbl[j].c);
        end

        // en every third cycle: acceptance on the 4th en edge, long stall keeps the count.
        raw_in = '0;
        do_reset();
        raw_in = 9'h001;
        repeat (3) step(1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1);
            chk($sformatf("en edge %0d x_out", k + 1), x_out, 0);
            step(1'b0);
            step(1'b0);
        end
        repeat (10) step(1'b0);
        chk("en stall x_out", x_out, 0);
        step(1'b1);
        chk("en edge 4 x_out", x_out, 9'h001);
        chk("en edge 4 rise", rise, 9'h001);
        chk("en edge 4 chg", chg, 1);
        step(1'b0);
        chk("en rise one cycle", rise, 0);
        chk("en hold x_out", x_out, 9'h001);

        // Stuck detection with limit 8.
        raw_in = '0;
        do_reset();
        raw_in = 9'h004;
        repeat (6) step(1'b1);
        chk("stuck x_out high", x_out, 9'h004);
        repeat (7) step(1'b1);
        chk("stuck before limit", stuck, 0);
        step(1'b1);
        chk("stuck at limit", stuck, 9'h004);
        stuck_clr = 1'b1;
        step(1'b1);
        stuck_clr = 1'b0;
        chk("stuck cleared", stuck, 0);
        repeat (7) step(1'b1);
        chk("stuck recount before", stuck, 0);
        step(1'b1);
        chk("stuck recount set", stuck, 9'h004);
        chk("stuck keeps x_out", x_out, 9'h004);
        stuck_clr = 1'b1;
        raw_in    = '0;
        step(1'b1);
        stuck_clr = 1'b0;
        repeat (5) step(1'b1);
        chk("stuck low x_out", x_out, 0);
        chk("stuck low no set", stuck, 0);
        raw_in = 9'h004;
        repeat (6) step(1'b1);
        repeat (7) step(1'b1);
        chk("stuck counter cleared", stuck, 0);
        step(1'b1);
        chk("stuck set again", stuck, 9'h004);

        // Reset while bit 3 is pending with cnt=2 and bit 8 already accepted.
        raw_in = '0;
        do_reset();
        raw_in = 9'h100;
        repeat (6) step(1'b1);
        raw_in = 9'h108;
        repeat (4) step(1'b1);
        chk("pre-reset x_out", x_out, 9'h100);
        rst = 1'b1;
        #1;
        chk("async reset x_out", x_out, 0);
        chk("async reset rise", rise, 0);
        chk("async reset chg", chg, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(1'b1);
            chk($sformatf("post-reset edge %0d x_out", k), x_out, 0);
        end
        step(1'b1);
        chk("post-reset accept x_out", x_out, 9'h108);
        chk("post-reset accept rise", rise, 9'h108);
        chk("post-reset accept chg", chg, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
